// File: rtl/vram_port_arbiter_if.sv
// Bundle of the CPU port, video fetch port and RAM-side signals around the VRAM arbiter.
// slave = arbiter side; master = requesters plus the RAM macro.
interface vram_port_arbiter_if #(
  parameter int AW = 11,
  parameter int DW = 8
);
  logic          vid_req;
  logic [AW-1:0] vid_addr;
  logic [DW-1:0] vid_data;
  logic          vid_valid;

  logic          cpu_req;
  logic          cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic [DW-1:0] cpu_rdata;
  logic          cpu_ack;

  logic [AW-1:0] ram_addr;
  logic          ram_we;
  logic [DW-1:0] ram_wdata;
  logic [DW-1:0] ram_rdata;

  logic          cpu_starve;
  logic          vid_overrun;

  modport slave (
    input  vid_req, vid_addr, cpu_req, cpu_we, cpu_addr, cpu_wdata, ram_rdata,
    output vid_data, vid_valid, cpu_rdata, cpu_ack, ram_addr, ram_we, ram_wdata,
           cpu_starve, vid_overrun
  );

  modport master (
    output vid_req, vid_addr, cpu_req, cpu_we, cpu_addr, cpu_wdata, ram_rdata,
    input  vid_data, vid_valid, cpu_rdata, cpu_ack, ram_addr, ram_we, ram_wdata,
           cpu_starve, vid_overrun
  );
endinterface

// File: rtl/vram_port_arbiter.sv
// Single-port VRAM arbiter: video fetch has priority, CPU takes free cycles; fixed 2-edge latency.
// Optional macro VRAM_ARB_FAIR_EN: starved CPU forces a grant and the displaced video read is deferred.
module vram_port_arbiter #(
  parameter int AW           = 11,
  parameter int DW           = 8,
  parameter int CPU_MAX_WAIT = 4
) (
  input logic                clk,
  input logic                rst,
  vram_port_arbiter_if.slave bus
);

  localparam logic [3:0] MAX_WAIT = 4'(CPU_MAX_WAIT);

  typedef enum logic [1:0] {
    GNT_IDLE,
    GNT_VID,
    GNT_PEND,
    GNT_CPU
  } gnt_e;

  typedef struct packed {
    logic vld;
    logic src;  // 1 = CPU, 0 = video
    logic we;
  } tag_t;

  gnt_e          gnt;
  logic          cpu_elig;
  logic          cpu_inflight;
  logic [3:0]    wait_cnt;
  logic [3:0]    wait_cnt_nxt;
  tag_t          iss_tag;
  tag_t          iss_tag_nxt;
  tag_t          ret_tag;
  logic [AW-1:0] iss_addr_nxt;

`ifdef VRAM_ARB_FAIR_EN
  logic          pend_vld;
  logic          pend_vld_nxt;
  logic [AW-1:0] pend_addr;
  logic [AW-1:0] pend_addr_nxt;
  logic          overrun_set;
  logic          force_cpu;
`endif

  // A held cpu_req must not be re-issued while its access is in flight or being acked.
  assign cpu_elig = bus.cpu_req & ~cpu_inflight & ~bus.cpu_ack;

  always_comb begin
    gnt = GNT_IDLE;
`ifdef VRAM_ARB_FAIR_EN
    pend_vld_nxt  = pend_vld;
    pend_addr_nxt = pend_addr;
    overrun_set   = 1'b0;
    force_cpu     = cpu_elig & (wait_cnt == MAX_WAIT) & ~pend_vld;
    if (pend_vld) begin
      gnt          = GNT_PEND;
      pend_vld_nxt = 1'b0;
      overrun_set  = bus.vid_req;
    end else if (force_cpu) begin
      gnt = GNT_CPU;
      if (bus.vid_req) begin
        pend_vld_nxt  = 1'b1;
        pend_addr_nxt = bus.vid_addr;
      end
    end else if (bus.vid_req) begin
      gnt = GNT_VID;
    end else if (cpu_elig) begin
      gnt = GNT_CPU;
    end
`else
    if (bus.vid_req) begin
      gnt = GNT_VID;
    end else if (cpu_elig) begin
      gnt = GNT_CPU;
    end
`endif
  end

  always_comb begin
    iss_tag_nxt  = '0;
    iss_addr_nxt = bus.ram_addr;
    case (gnt)
      GNT_VID: begin
        iss_tag_nxt  = '{vld: 1'b1, src: 1'b0, we: 1'b0};
        iss_addr_nxt = bus.vid_addr;
      end
`ifdef VRAM_ARB_FAIR_EN
      GNT_PEND: begin
        iss_tag_nxt  = '{vld: 1'b1, src: 1'b0, we: 1'b0};
        iss_addr_nxt = pend_addr;
      end
`endif
      GNT_CPU: begin
        iss_tag_nxt  = '{vld: 1'b1, src: 1'b1, we: bus.cpu_we};
        iss_addr_nxt = bus.cpu_addr;
      end
      default: ;
    endcase
  end

  always_comb begin
    wait_cnt_nxt = 4'd0;
    if (cpu_elig && (gnt != GNT_CPU)) begin
      wait_cnt_nxt = (wait_cnt >= MAX_WAIT) ? MAX_WAIT : wait_cnt + 4'd1;
    end
  end

  // Issue stage: RAM control registers and the tag that travels with the access.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.ram_addr  <= '0;
      bus.ram_we    <= 1'b0;
      bus.ram_wdata <= '0;
      iss_tag       <= '0;
      cpu_inflight  <= 1'b0;
      wait_cnt      <= 4'd0;
    end else begin
      bus.ram_addr <= iss_addr_nxt;
      bus.ram_we   <= iss_tag_nxt.vld & iss_tag_nxt.src & iss_tag_nxt.we;
      if (gnt == GNT_CPU && bus.cpu_we) begin
        bus.ram_wdata <= bus.cpu_wdata;
      end
      iss_tag  <= iss_tag_nxt;
      wait_cnt <= wait_cnt_nxt;
      if (gnt == GNT_CPU) begin
        cpu_inflight <= 1'b1;
      end else if (ret_tag.vld && ret_tag.src) begin
        cpu_inflight <= 1'b0;
      end
    end
  end

  // Return stage: RAM q is valid one edge after the issue registers, captured the edge after.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ret_tag       <= '0;
      bus.vid_valid <= 1'b0;
      bus.vid_data  <= '0;
      bus.cpu_ack   <= 1'b0;
      bus.cpu_rdata <= '0;
    end else begin
      ret_tag       <= iss_tag;
      bus.vid_valid <= ret_tag.vld & ~ret_tag.src;
      bus.cpu_ack   <= ret_tag.vld & ret_tag.src;
      if (ret_tag.vld && !ret_tag.src) begin
        bus.vid_data <= bus.ram_rdata;
      end
      if (ret_tag.vld && ret_tag.src && !ret_tag.we) begin
        bus.cpu_rdata <= bus.ram_rdata;
      end
    end
  end

`ifdef VRAM_ARB_FAIR_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_vld        <= 1'b0;
      pend_addr       <= '0;
      bus.vid_overrun <= 1'b0;
    end else begin
      pend_vld  <= pend_vld_nxt;
      pend_addr <= pend_addr_nxt;
      if (overrun_set) begin
        bus.vid_overrun <= 1'b1;
      end
    end
  end

  assign bus.cpu_starve = 1'b0;
`else
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.cpu_starve <= 1'b0;
    end else if (wait_cnt_nxt == MAX_WAIT) begin
      bus.cpu_starve <= 1'b1;
    end
  end

  assign bus.vid_overrun = 1'b0;
`endif

endmodule

// File: tb/tb_vram_port_arbiter.sv
// Directed bench for vram_port_arbiter with a behavioural 2K x 8 synchronous RAM.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_vram_port_arbiter;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;
  int   lat;
  int   cnt;
  int   ack_t;

  logic [7:0] mem [2048];

  vram_port_arbiter_if #(.AW(11), .DW(8)) bus ();

  vram_port_arbiter #(.AW(11), .DW(8), .CPU_MAX_WAIT(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM model; known contents are (re)loaded whenever reset is high.
  always @(posedge clk) begin
    if (rst) begin
      mem[11'h400] <= 8'h5A;
      mem[11'h123] <= 8'h77;
      for (int i = 0; i < 6; i++) mem[11'h410 + 11'(i)] <= 8'h20 + 8'(i);
      bus.ram_rdata <= 8'h00;
    end else begin
      if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_wdata;
      bus.ram_rdata <= mem[bus.ram_addr];
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Returns the number of falling edges until cpu_ack is seen, or -1 if it never comes.
  task automatic wait_ack(output int n);
    n = -1;
    for (int t = 1; t <= 8; t++) begin
      tick();
      if (bus.cpu_ack) begin
        n = t;
        break;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst = 1'b1;
    bus.vid_req = 1'b0;  bus.vid_addr = '0;
    bus.cpu_req = 1'b0;  bus.cpu_we = 1'b0;
    bus.cpu_addr = '0;   bus.cpu_wdata = '0;
    repeat (3) tick();
    chk("rst_vid_valid", bus.vid_valid, 0);
    chk("rst_cpu_ack",   bus.cpu_ack, 0);
    chk("rst_ram_we",    bus.ram_we, 0);
    chk("rst_ram_addr",  bus.ram_addr, 0);
    chk("rst_starve",    bus.cpu_starve, 0);
    chk("rst_overrun",   bus.vid_overrun, 0);
    rst = 1'b0;
    tick();

    // 1: lone video read, valid two edges after the issue edge
    bus.vid_req = 1'b1; bus.vid_addr = 11'h400;
    tick();
    bus.vid_req = 1'b0;
    chk("t1_ram_addr", bus.ram_addr, 32'h400);
    chk("t1_valid_e1", bus.vid_valid, 0);
    tick();
    chk("t1_valid_e2", bus.vid_valid, 0);
    tick();
    chk("t1_valid_e3", bus.vid_valid, 1);
    chk("t1_data",     bus.vid_data, 32'h5A);
    tick();
    chk("t1_valid_e4", bus.vid_valid, 0);
    chk("t1_data_hold", bus.vid_data, 32'h5A);

    // 2: CPU write with cpu_req held three cycles, then read back
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = 11'h7FF; bus.cpu_wdata = 8'hC3;
    cnt = 0;
    for (int t = 1; t <= 5; t++) begin
      tick();
      if (bus.ram_we) cnt++;
      if (t == 1) chk("t2_ram_wdata", bus.ram_wdata, 32'hC3);
      if (t == 2) chk("t2_ack_e2", bus.cpu_ack, 0);
      if (t == 3) begin
        chk("t2_ack_e3", bus.cpu_ack, 1);
        bus.cpu_req = 1'b0;
      end
    end
    chk("t2_we_pulses", cnt, 1);
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0;
    wait_ack(lat);
    bus.cpu_req = 1'b0;
    chk("t2_rd_latency", lat, 3);
    chk("t2_rdata", bus.cpu_rdata, 32'hC3);
    tick();

    // 3: simultaneous requests, video first, CPU next edge
    bus.vid_req = 1'b1; bus.vid_addr = 11'h400;
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 11'h7FF;
    tick();
    bus.vid_req = 1'b0;
    chk("t3_vid_issue", bus.ram_addr, 32'h400);
    tick();
    chk("t3_cpu_issue", bus.ram_addr, 32'h7FF);
    tick();
    chk("t3_vid_valid", bus.vid_valid, 1);
    chk("t3_ack_early", bus.cpu_ack, 0);
    tick();
    chk("t3_cpu_ack",   bus.cpu_ack, 1);
    chk("t3_vid_drop",  bus.vid_valid, 0);
    chk("t3_rdata",     bus.cpu_rdata, 32'hC3);
    bus.cpu_req = 1'b0;
    tick();

    // 4/5: six back-to-back video reads against a held CPU read
    bus.vid_req = 1'b1; bus.vid_addr = 11'h410;
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 11'h123;
    cnt = 0; ack_t = -1;
    for (int t = 1; t <= 12; t++) begin
      tick();
      if (bus.vid_valid) cnt++;
      if (bus.cpu_ack && ack_t < 0) begin
        ack_t = t;
        chk("t45_rdata", bus.cpu_rdata, 32'h77);
        bus.cpu_req = 1'b0;
      end
`ifndef VRAM_ARB_FAIR_EN
      if (t <= 6) chk("t4_vid_issue", bus.ram_addr, 32'h410 + 32'(t - 1));
      if (t == 3) chk("t4_starve_e3", bus.cpu_starve, 0);
      if (t == 4) chk("t4_starve_e4", bus.cpu_starve, 1);
      if (t == 7) chk("t4_cpu_issue", bus.ram_addr, 32'h123);
`else
      if (t == 4) chk("t5_vid_issue", bus.ram_addr, 32'h413);
      if (t == 5) chk("t5_cpu_issue", bus.ram_addr, 32'h123);
      if (t == 5) chk("t5_overrun_e5", bus.vid_overrun, 0);
      if (t == 6) chk("t5_pend_issue", bus.ram_addr, 32'h414);
      if (t == 6) chk("t5_overrun_e6", bus.vid_overrun, 1);
      if (t == 7) chk("t5_valid_gap", bus.vid_valid, 0);
      if (t == 8) begin
        chk("t5_pend_valid", bus.vid_valid, 1);
        chk("t5_pend_data",  bus.vid_data, 32'h24);
      end
`endif
      bus.vid_req  = (t < 6);
      bus.vid_addr = 11'h410 + 11'(t);
    end
`ifndef VRAM_ARB_FAIR_EN
    chk("t4_ack_edge",  ack_t, 9);
    chk("t4_vid_count", cnt, 6);
    chk("t4_starve_sticky", bus.cpu_starve, 1);
`else
    chk("t5_ack_edge",  ack_t, 7);
    chk("t5_vid_count", cnt, 5);
    chk("t5_no_starve", bus.cpu_starve, 0);
`endif

    // 6: reset between issue and return of a CPU read
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 11'h7FF;
    tick();
    chk("t6_issued", bus.ram_addr, 32'h7FF);
    rst = 1'b1;
    #1;
    chk("t6_ram_we",   bus.ram_we, 0);
    chk("t6_ram_addr", bus.ram_addr, 0);
    chk("t6_starve",   bus.cpu_starve, 0);
    chk("t6_overrun",  bus.vid_overrun, 0);
    bus.cpu_req = 1'b0;
    cnt = 0;
    for (int t = 1; t <= 3; t++) begin
      tick();
      if (bus.cpu_ack) cnt++;
    end
    rst = 1'b0;
    tick();
    if (bus.cpu_ack) cnt++;
    chk("t6_no_ack", cnt, 0);
    bus.cpu_req = 1'b1;
    wait_ack(lat);
    bus.cpu_req = 1'b0;
    chk("t6_post_latency", lat, 3);
    chk("t6_post_rdata",   bus.cpu_rdata, 32'hC3);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
